// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that lends one shared combinational logic unit to two requesters.
// Response appears SETTLE+1 cycles after accept and is held until rsp_ready; the arbiter accepts nothing while busy.
module logic_unit_arbiter #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req0_op,
   input  logic [1:0]       req1_op,
   output logic [WIDTH-1:0] lu_a,
   output logic [WIDTH-1:0] lu_b,
   output logic [1:0]       lu_op,
   input  logic [WIDTH-1:0] lu_y,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_y,
   input  logic             rsp_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_cnt;
   logic             r_last;
   logic [WIDTH-1:0] r_lu_a;
   logic [WIDTH-1:0] r_lu_b;
   logic [1:0]       r_lu_op;
   logic             r_rsp_id;
   logic [WIDTH-1:0] r_rsp_y;
   logic             w_accept;
   logic             w_grant_id;

   // req_ready is masked by reset so no accept strobe is shown in a cycle that reset discards
   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_grant_id = 1'b0;
      req_ready  = 2'b00;
      case (r_state)
         ST_IDLE: begin
            if (!reset && (req_valid != 2'b00)) begin
               w_accept = 1'b1;
               if (req_valid == 2'b11) begin
                  w_grant_id = ~r_last;
               end else begin
                  w_grant_id = req_valid[1];
               end
               req_ready = w_grant_id ? 2'b10 : 2'b01;
               w_next    = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_cnt == 4'd1) begin
               w_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 4'd0;
         r_last   <= 1'b1;
         r_lu_a   <= '0;
         r_lu_b   <= '0;
         r_lu_op  <= 2'b00;
         r_rsp_id <= 1'b0;
         r_rsp_y  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_lu_a   <= w_grant_id ? req1_a  : req0_a;
            r_lu_b   <= w_grant_id ? req1_b  : req0_b;
            r_lu_op  <= w_grant_id ? req1_op : req0_op;
            r_rsp_id <= w_grant_id;
            r_last   <= w_grant_id;
            r_cnt    <= SETTLE_CNT;
         end else if (r_state == ST_SETTLE) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               r_rsp_y <= lu_y;
            end
         end
      end
   end

   assign lu_a      = r_lu_a;
   assign lu_b      = r_lu_b;
   assign lu_op     = r_lu_op;
   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_id    = r_rsp_id;
   assign rsp_y     = r_rsp_y;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits.
REQ-002 SHALL have parameter SETTLE, default 2: cycles operands are held on the shared unit before sampling; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 2: per-requester request valid (bit i = requester i).
REQ-006 SHALL have port req_ready, output, 2: per-requester accept strobe.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, WIDTH each: requester operands.
REQ-008 SHALL have ports req0_op, req1_op, input, 2 each: requester operation code, passed through unmodified.
REQ-009 SHALL have ports lu_a, lu_b, output, WIDTH each; lu_op, output, 2: registered drive to the shared combinational logic unit.
REQ-010 SHALL have port lu_y, input, WIDTH: combinational result from the shared unit.
REQ-011 SHALL have ports rsp_valid, output, 1; rsp_id, output, 1; rsp_y, output, WIDTH: response to the owning requester.
REQ-012 SHALL have port rsp_ready, input, 1: response consumer ready.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, SETTLE, RESP.
REQ-015 In IDLE with at least one req_valid bit set, SHALL assert exactly one req_ready bit combinationally in that cycle; that cycle is the accept.
REQ-016 Arbitration SHALL be round-robin: when both are valid, grant the requester not granted last; when one is valid, grant it regardless of history.
REQ-017 On accept, SHALL register the winner's a/b/op onto lu_a/lu_b/lu_op, record its id, load the settle counter with SETTLE, and enter SETTLE.
REQ-018 req_ready SHALL be 0 in SETTLE and RESP; requests arriving then wait, and no request is lost or duplicated.
REQ-019 In SETTLE the counter SHALL decrement each cycle; in the cycle the counter equals 1, SHALL capture lu_y into rsp_y and enter RESP.
REQ-020 Latency: accept in cycle N SHALL produce rsp_valid=1 first in cycle N+SETTLE+1.
REQ-021 lu_a/lu_b/lu_op SHALL remain stable from the accept until the next accept, and are never modified during SETTLE or RESP.
REQ-022 In RESP, rsp_valid SHALL be 1, with rsp_id and rsp_y held stable until rsp_ready=1; on that cycle the state SHALL return to IDLE.
REQ-023 No accept SHALL occur in the rsp_valid&rsp_ready cycle; the earliest next accept is the following cycle, so peak throughput is one operation per SETTLE+2 cycles.
REQ-024 The round-robin pointer SHALL update only on accept.
REQ-025 Deasserting req_valid before its req_ready SHALL be legal and leave no side effect.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE, with req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, lu_a=0, lu_b=0, lu_op=0, busy=0, settle counter=0, and last-grant=1 so requester 0 wins the first tie.
REQ-027 reset asserted in SETTLE or RESP SHALL discard the in-flight operation without producing a response; reset SHALL take priority over every other event in the same cycle.

Verification
REQ-028 SETTLE=2, req0 valid alone with a=8'hF0, b=8'h3C, op=0, unit=AND -> req_ready=2'b01 at cycle 0; rsp_valid at cycle 3 with rsp_id=0, rsp_y=8'h30.
REQ-029 Both valid in the same cycle after reset -> requester 0 granted first, requester 1 granted in the cycle after the first response handshake; two responses, ids 0 then 1.
REQ-030 Both held continuously valid for 4 operations -> grant sequence 0,1,0,1; no back-to-back grant to the same requester.
REQ-031 rsp_ready held 0 for 3 cycles in RESP -> rsp_valid, rsp_id, rsp_y and lu_* unchanged across those cycles; busy=1; req_ready=0.
REQ-032 reset pulsed one cycle during SETTLE -> next cycle IDLE with all outputs at reset values and no rsp_valid; a subsequent req1 request completes normally.
